// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the reset sequencer: FSM states, default
// timing parameters and the counter width helper.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      StHold,
      StStretch,
      StRelease,
      StRun
   } state_e;

   localparam int unsigned DefSyncStages = 2;
   localparam int unsigned DefStretch    = 8;
   localparam int unsigned DefGap        = 4;
   localparam int unsigned DefNumOut     = 3;

   // Wide enough to hold the larger of the two reload values.
   function automatic int unsigned cnt_width(input int unsigned stretch,
                                             input int unsigned gap);
      int unsigned m;
      m = (stretch > gap) ? stretch : gap;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Software request / reset output bundle between the sequencer (slave) and
// whatever drives sw_req and consumes the resets (master).
interface reset_sequencer_if
   import reset_seq_pkg::*;
#(
   parameter int unsigned NUM_OUT = DefNumOut
);
   logic               sw_req;
   logic [NUM_OUT-1:0] rst_out;
   logic               sw_ack;
   logic               busy;
   logic               seq_done;

   modport master (
      output sw_req,
      input  rst_out,
      input  sw_ack,
      input  busy,
      input  seq_done
   );

   modport slave (
      input  sw_req,
      output rst_out,
      output sw_ack,
      output busy,
      output seq_done
   );
endinterface

// File: rtl/reset_sync.sv
// Deassertion synchroniser: clears asynchronously, shifts in a 1 after the
// reset pin rises, output goes high after STAGES rising edges.
module reset_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   output logic sync_o
);
   logic [STAGES-1:0] chain_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[STAGES-2:0], 1'b1};
      end
   end

   assign sync_o = chain_q[STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// Reset source for sync-reset register banks: immediate assertion, then a
// synchronised, stretched and staggered release of NUM_OUT active-high resets.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = DefSyncStages,
   parameter int unsigned STRETCH     = DefStretch,
   parameter int unsigned GAP         = DefGap,
   parameter int unsigned NUM_OUT     = DefNumOut
) (
   input logic              clk,
   input logic              reset,
   reset_sequencer_if.slave bus
);
   localparam int unsigned CntW = cnt_width(STRETCH, GAP);
   localparam int unsigned IdxW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

   logic               sync_out;
   state_e             state_q;
   logic [CntW-1:0]    cnt_q;
   logic [IdxW-1:0]    idx_q;
   logic [NUM_OUT-1:0] rst_out_q;
   logic               sw_ack_q;
   logic               busy_q;
   logic               seq_done_q;
   logic               stretch_done;

   reset_sync #(
      .STAGES(SYNC_STAGES)
   ) u_reset_sync (
      .clk   (clk),
      .reset (reset),
      .sync_o(sync_out)
   );

   // The HOLD exit edge is the first stretch edge of a power-on release.
   always_comb begin
      stretch_done = ((state_q == StStretch) && (cnt_q == CntW'(1))) ||
                     ((state_q == StHold) && sync_out && (STRETCH == 1));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StHold;
         cnt_q      <= '0;
         idx_q      <= '0;
         rst_out_q  <= '1;
         sw_ack_q   <= 1'b0;
         busy_q     <= 1'b1;
         seq_done_q <= 1'b0;
      end else begin
         sw_ack_q <= 1'b0;
         unique case (state_q)
            StHold: begin
               if (sync_out) begin
                  state_q <= StStretch;
                  cnt_q   <= CntW'(STRETCH - 1);
               end
            end
            StStretch: begin
               cnt_q <= cnt_q - CntW'(1);
            end
            StRelease: begin
               if (cnt_q == CntW'(1)) begin
                  rst_out_q <= rst_out_q << 1;
                  if (idx_q == IdxW'(NUM_OUT - 1)) begin
                     state_q    <= StRun;
                     busy_q     <= 1'b0;
                     seq_done_q <= 1'b1;
                  end else begin
                     idx_q <= idx_q + IdxW'(1);
                     cnt_q <= CntW'(GAP);
                  end
               end else begin
                  cnt_q <= cnt_q - CntW'(1);
               end
            end
            StRun: begin
               if (bus.sw_req) begin
                  state_q    <= StStretch;
                  cnt_q      <= CntW'(STRETCH);
                  rst_out_q  <= '1;
                  sw_ack_q   <= 1'b1;
                  busy_q     <= 1'b1;
                  seq_done_q <= 1'b0;
               end
            end
            default: state_q <= StHold;
         endcase

         // Final stretch edge overrides the per-state updates above.
         if (stretch_done) begin
            rst_out_q <= rst_out_q << 1;
            cnt_q     <= CntW'(GAP);
            idx_q     <= IdxW'(1);
            if (NUM_OUT == 1) begin
               state_q    <= StRun;
               busy_q     <= 1'b0;
               seq_done_q <= 1'b1;
            end else begin
               state_q <= StRelease;
            end
         end
      end
   end

   assign bus.rst_out  = rst_out_q;
   assign bus.sw_ack   = sw_ack_q;
   assign bus.busy     = busy_q;
   assign bus.seq_done = seq_done_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a
// NUM_OUT=1 / STRETCH=1 / SYNC_STAGES=3 instance.
module tb_reset_sequencer;
   logic clk = 1'b0;
   logic reset;
   logic reset2;

   always #5 clk = ~clk;

   reset_sequencer_if #(.NUM_OUT(3)) bus ();
   reset_sequencer_if #(.NUM_OUT(1)) bus2 ();

   reset_sequencer #(
      .SYNC_STAGES(2),
      .STRETCH    (8),
      .GAP        (4),
      .NUM_OUT    (3)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   reset_sequencer #(
      .SYNC_STAGES(3),
      .STRETCH    (1),
      .GAP        (4),
      .NUM_OUT    (1)
   ) dut2 (
      .clk  (clk),
      .reset(reset2),
      .bus  (bus2)
   );

   typedef struct {
      int         seq;
      int         edge_no;
      logic       sw;
      logic [2:0] rst;
      logic       busy;
      logic       done;
      logic       ack;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   function automatic logic [5:0] obs1();
      return {bus.rst_out, bus.busy, bus.seq_done, bus.sw_ack};
   endfunction

   function automatic logic [5:0] obs2();
      return {2'b00, bus2.rst_out, bus2.busy, bus2.seq_done, bus2.sw_ack};
   endfunction

   // Edge 1 is the first rising edge after the call; call between edges.
   task automatic run_seq(input int seq, input bit allow_sw, input string tag);
      int cur = 0;
      foreach (vecs[i]) begin
         if (vecs[i].seq == seq) begin
            while (cur < vecs[i].edge_no) begin
               bus.sw_req = allow_sw ? vecs[i].sw : 1'b0;
               @(posedge clk);
               #1;
               cur++;
            end
            check($sformatf("%s edge %0d", tag, vecs[i].edge_no), obs1(),
                  {vecs[i].rst, vecs[i].busy, vecs[i].done, vecs[i].ack});
         end
      end
      bus.sw_req = 1'b0;
   endtask

   int acks;

   initial begin
      // seq 0: release after reset pin rises (sw column used only when allowed)
      vecs.push_back('{0,  1, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{0,  5, 1'b1, 3'b111, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{0,  9, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{0, 10, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{0, 12, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{0, 13, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{0, 14, 1'b0, 3'b100, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{0, 17, 1'b0, 3'b100, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{0, 18, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{0, 20, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0});
      // seq 1: software request accepted at edge 1 (T)
      vecs.push_back('{1,  1, 1'b1, 3'b111, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{1,  2, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1,  8, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1,  9, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1, 12, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1, 13, 1'b0, 3'b100, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1, 16, 1'b0, 3'b100, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1, 17, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0});

      bus.sw_req  = 1'b0;
      bus2.sw_req = 1'b0;
      reset       = 1'b1;
      reset2      = 1'b1;
      #1;
      reset  = 1'b0;
      reset2 = 1'b0;
      #1;
      check("reset state", obs1(), 6'b111_1_0_0);
      check("reset state dut2", obs2(), 6'b00_1_1_0_0);
      repeat (3) @(posedge clk);
      #1;
      check("held in reset", obs1(), 6'b111_1_0_0);

      @(negedge clk);
      reset = 1'b1;
      run_seq(0, 1'b0, "poweron");

      // Glitch shorter than a clock period, landing between edges
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("glitch assert", obs1(), 6'b111_1_0_0);
      #1;
      reset = 1'b1;
      run_seq(0, 1'b0, "glitch");

      @(negedge clk);
      run_seq(1, 1'b1, "swreset");

      // Requests during STRETCH and RELEASE must be ignored
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      run_seq(0, 1'b1, "busyreq");

      // Abort in the middle of RELEASE
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("midrel before", obs1(), 6'b110_1_0_0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrel assert", obs1(), 6'b111_1_0_0);
      @(negedge clk);
      reset = 1'b1;
      run_seq(0, 1'b0, "midrel");

      // Continuous request: accepted on entry to RUN at edges 1, 18, 35
      @(negedge clk);
      bus.sw_req = 1'b1;
      acks = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.sw_ack === 1'b1) acks++;
         if (i == 18) check("held edge 18", obs1(), 6'b111_1_0_1);
      end
      bus.sw_req = 1'b0;
      check("held ack count", 6'(acks), 6'd3);

      // Single output, STRETCH=1, three sync stages
      @(negedge clk);
      reset2 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("sweep edge 3", obs2(), 6'b00_1_1_0_0);
      @(posedge clk);
      #1;
      check("sweep edge 4", obs2(), 6'b00_0_0_1_0);
      @(negedge clk);
      bus2.sw_req = 1'b1;
      @(posedge clk);
      #1;
      bus2.sw_req = 1'b0;
      check("sweep sw accept", obs2(), 6'b00_1_1_0_1);
      @(posedge clk);
      #1;
      check("sweep sw release", obs2(), 6'b00_0_0_1_0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
